// File: rtl/easyaxi_pkg.sv
// Shared definitions for the EasyAXI read master.
//   - AXI burst/response encodings
//   - AR request FSM state encoding
//   - clog2 helper for arsize and counter widths
package easyaxi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } ar_state_e;

    // ceil(log2(value)); clog2(1) == 0
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/easyaxi_ost_cnt.sv
// Outstanding-burst counter.
//   clk, rst_n : clock, async active-low reset
//   inc, dec   : request +1 / -1; both together leave the count unchanged
//   count      : current value (0..MAX)
//   full       : count == MAX
// Increments are dropped at MAX and decrements at 0, so the count never
// leaves its range even if the far side misbehaves.
module easyaxi_ost_cnt #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full
);

    assign full = (count == W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (!full) count <= count + 1'b1;
        end else if (dec && !inc) begin
            if (count != '0) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/easyaxi_rd_mst.sv
// EasyAXI read master: issues INCR bursts on AR at consecutive aligned
// addresses, consumes R beats, checks response integrity and counts
// completed bursts.
//   clk, rst_n        : clock, async active-low reset
//   enable            : permits new AR requests
//   axi_mst_ar*       : AR channel (constant id/len/size/burst)
//   axi_mst_r*        : R channel (rdata is not inspected)
//   busy              : bursts outstanding or AR pending
//   err               : sticky response error
//   done_cnt          : completed bursts, wraps at 2^16
// All outputs come from registers; there is no input-to-output path.
module easyaxi_rd_mst
    import easyaxi_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] MST_ID    = '0,
    parameter int              BURST_LEN = 4,
    parameter int              MAX_OST   = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              axi_mst_arvalid,
    input  logic              axi_mst_arready,
    output logic [ADDR_W-1:0] axi_mst_araddr,
    output logic [ID_W-1:0]   axi_mst_arid,
    output logic [7:0]        axi_mst_arlen,
    output logic [2:0]        axi_mst_arsize,
    output logic [1:0]        axi_mst_arburst,
    input  logic              axi_mst_rvalid,
    output logic              axi_mst_rready,
    input  logic [DATA_W-1:0] axi_mst_rdata,
    input  logic [1:0]        axi_mst_rresp,
    input  logic              axi_mst_rlast,
    input  logic [ID_W-1:0]   axi_mst_rid,
    output logic              busy,
    output logic              err,
    output logic [15:0]       done_cnt
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BEAT_W = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1;
    localparam int OST_W  = clog2(MAX_OST + 1);
    localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(BURST_LEN * BYTES);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    ar_state_e         state_q, state_d;
    logic [ADDR_W-1:0] araddr_q;
    logic [BEAT_W-1:0] beat_cnt;
    logic [OST_W-1:0]  ost_cnt;
    logic              ost_full;
    logic              rready_q;
    logic              err_q;
    logic [15:0]       done_q;
    logic              ar_hs, r_hs, r_fault;
    logic              rdata_unused;

    assign rdata_unused = ^axi_mst_rdata;

    assign ar_hs = (state_q == ST_REQ) && axi_mst_arready;
    assign r_hs  = axi_mst_rvalid && rready_q;

    // rlast always closes the head burst, even when it arrives on the wrong
    // beat, so a misbehaving slave cannot wedge the outstanding count.
    easyaxi_ost_cnt #(
        .MAX (MAX_OST),
        .W   (OST_W)
    ) u_ost (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ar_hs),
        .dec   (r_hs && axi_mst_rlast),
        .count (ost_cnt),
        .full  (ost_full)
    );

    // AR FSM: IDLE between requests caps the rate at one AR per two cycles
    // and lets the limit check see the updated registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable && !ost_full) state_d = ST_REQ;
            ST_REQ:  if (axi_mst_arready)     state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With a single ID responses are in order, so one beat counter for the
    // head burst suffices.
    assign r_fault = (axi_mst_rresp != AXI_RESP_OKAY)
                   || (axi_mst_rid != MST_ID)
                   || (axi_mst_rlast != (beat_cnt == LAST_BEAT))
                   || (ost_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_q <= BASE_ADDR;
            beat_cnt <= '0;
            rready_q <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= '0;
        end else begin
            if (ar_hs) araddr_q <= araddr_q + ADDR_INC;
            rready_q <= (ost_cnt != '0);
            if (r_hs) begin
                beat_cnt <= axi_mst_rlast ? '0 : beat_cnt + 1'b1;
                if (r_fault)       err_q  <= 1'b1;
                if (axi_mst_rlast) done_q <= done_q + 16'd1;
            end
        end
    end

    assign axi_mst_arvalid = (state_q == ST_REQ);
    assign axi_mst_araddr  = araddr_q;
    assign axi_mst_arid    = MST_ID;
    assign axi_mst_arlen   = 8'(BURST_LEN - 1);
    assign axi_mst_arsize  = 3'(clog2(BYTES));
    assign axi_mst_arburst = AXI_BURST_INCR;
    assign axi_mst_rready  = rready_q;
    assign busy            = (ost_cnt != '0) || axi_mst_arvalid;
    assign err             = err_q;
    assign done_cnt        = done_q;

endmodule

// File: tb/tb_easyaxi_rd_mst.sv
module tb_easyaxi_rd_mst;
    import easyaxi_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic arvalid, arready = 1'b0, rready, busy, err;
    logic [31:0] araddr, rdata = '0;
    logic [3:0]  arid, rid = '0;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp = '0;
    logic rvalid = 1'b0, rlast = 1'b0;
    logic [15:0] done_cnt;

    // second instance: 8-bit address space starting near the top
    logic w_enable = 1'b0, w_arvalid, w_arready = 1'b1, w_rready, w_busy, w_err;
    logic [7:0]  w_araddr;
    logic [3:0]  w_arid;
    logic [7:0]  w_arlen;
    logic [2:0]  w_arsize;
    logic [1:0]  w_arburst;
    logic [15:0] w_done;
    logic        w_rvalid = 1'b0, w_rlast = 1'b0;
    logic [31:0] w_rdata = '0;
    logic [1:0]  w_rresp = '0;
    logic [3:0]  w_rid = '0;

    easyaxi_rd_mst dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .axi_mst_arvalid(arvalid), .axi_mst_arready(arready), .axi_mst_araddr(araddr),
        .axi_mst_arid(arid), .axi_mst_arlen(arlen), .axi_mst_arsize(arsize),
        .axi_mst_arburst(arburst), .axi_mst_rvalid(rvalid), .axi_mst_rready(rready),
        .axi_mst_rdata(rdata), .axi_mst_rresp(rresp), .axi_mst_rlast(rlast),
        .axi_mst_rid(rid), .busy(busy), .err(err), .done_cnt(done_cnt));

    easyaxi_rd_mst #(.ADDR_W(8), .BASE_ADDR(8'hF0)) dut_w (
        .clk(clk), .rst_n(rst_n), .enable(w_enable),
        .axi_mst_arvalid(w_arvalid), .axi_mst_arready(w_arready), .axi_mst_araddr(w_araddr),
        .axi_mst_arid(w_arid), .axi_mst_arlen(w_arlen), .axi_mst_arsize(w_arsize),
        .axi_mst_arburst(w_arburst), .axi_mst_rvalid(w_rvalid), .axi_mst_rready(w_rready),
        .axi_mst_rdata(w_rdata), .axi_mst_rresp(w_rresp), .axi_mst_rlast(w_rlast),
        .axi_mst_rid(w_rid), .busy(w_busy), .err(w_err), .done_cnt(w_done));

    always #5 clk = ~clk;

    typedef struct { int len; int bad; } burst_t;
    burst_t q[$];

    int checks = 0, errors = 0;
    int ar_cnt, ar_quota, served, serve_limit, beat_idx, exp_ost, exp_done;
    int inj_len = 4, inj_bad = -1;
    logic [31:0] exp_addr, ar_pend_addr;
    bit model_err, prev_ost_nz, arready_en, ar_rand, sync_ar, simul_seen;
    bit r_taken, gaps, ar_pend;

    // Slave R driver: serves queued bursts in order, holds a beat until taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid = 1'b0; rlast = 1'b0; rresp = AXI_RESP_OKAY; r_taken = 1'b0;
        end else begin
            #1;
            if (!(rvalid && !r_taken)) begin
                r_taken = 1'b0;
                if (q.size() > 0 && served < serve_limit && (!gaps || $urandom_range(0, 3) != 0)) begin
                    rvalid = 1'b1;
                    rlast  = (beat_idx == q[0].len - 1);
                    rresp  = (beat_idx == q[0].bad) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    rdata  = $urandom;
                end else begin
                    rvalid = 1'b0; rlast = 1'b0; rresp = AXI_RESP_OKAY;
                end
            end
        end
    end

    // AR ready driver, handshake monitor and reference model.
    always @(negedge clk) begin : bfm
        logic ar_hs, r_hs, fault;
        logic [2:0] ost_obs;
        if (rst_n) begin
            arready = (arready_en && ar_cnt < ar_quota && (!ar_rand || $urandom_range(0, 1) == 1))
                      || (sync_ar && rvalid && rready && rlast);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            checks++;
            if (err !== model_err) begin
                errors++; $display("FAIL err_model: got %b expected %b", err, model_err);
            end
            checks++;
            if (done_cnt !== exp_done[15:0]) begin
                errors++; $display("FAIL done_model: got %0d expected %0d", done_cnt, exp_done[15:0]);
            end
            checks++;
            if (rready !== prev_ost_nz) begin
                errors++; $display("FAIL rready_model: got %b expected %b", rready, prev_ost_nz);
            end
            ost_obs = dut.u_ost.count;
            checks++;
            if (ost_obs !== 3'(exp_ost)) begin
                errors++; $display("FAIL ost_model: got %0d expected %0d", ost_obs, exp_ost);
            end
            if (!arvalid) begin
                checks++;
                if (busy !== (exp_ost != 0)) begin
                    errors++; $display("FAIL busy_model: got %b expected %b", busy, exp_ost != 0);
                end
            end
            if (ar_pend) begin
                checks++;
                if (arvalid !== 1'b1 || araddr !== ar_pend_addr) begin
                    errors++;
                    $display("FAIL ar_stable: got v=%b a=%h expected v=1 a=%h", arvalid, araddr, ar_pend_addr);
                end
            end
            ar_pend = arvalid && !arready;
            ar_pend_addr = araddr;
            prev_ost_nz = (exp_ost != 0);
            if (ar_hs) begin
                checks++;
                if (araddr !== exp_addr) begin
                    errors++; $display("FAIL ar_addr: got %h expected %h", araddr, exp_addr);
                end
                exp_addr += 32'h10;
                q.push_back('{inj_len, inj_bad});
                ar_cnt++;
            end
            if (r_hs) begin
                fault = (rresp != AXI_RESP_OKAY) || (rid != 4'd0)
                        || (rlast != (beat_idx == 3)) || (exp_ost == 0);
                model_err |= fault;
                r_taken = 1'b1;
                if (rlast) begin
                    exp_done++; beat_idx = 0; served++;
                    if (q.size() > 0) void'(q.pop_front());
                end else beat_idx++;
            end
            if (ar_hs && r_hs && rlast) simul_seen = 1'b1;
            if (ar_hs && !(r_hs && rlast)) exp_ost++;
            else if (!ar_hs && r_hs && rlast && exp_ost > 0) exp_ost--;
        end
    end

    task automatic clear_model();
        q.delete();
        ar_cnt = 0; served = 0; serve_limit = 1 << 30; ar_quota = 1 << 30; beat_idx = 0;
        exp_ost = 0; exp_done = 0; exp_addr = 0; model_err = 0; prev_ost_nz = 0;
        arready_en = 1; ar_rand = 0; sync_ar = 0; simul_seen = 0; gaps = 0; ar_pend = 0;
        inj_len = 4; inj_bad = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; w_enable = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic drain(input string tag);
        int t;
        enable = 0; arready_en = 1; ar_quota = 1 << 30; serve_limit = 1 << 30;
        sync_ar = 0; ar_rand = 0;
        for (t = 0; t < 600; t++) begin
            cyc(1);
            if (!busy && q.size() == 0) break;
        end
        checks++;
        if (t >= 600) begin errors++; $display("FAIL %s_drain: got busy=%b expected idle", tag, busy); end
        cyc(2);
    endtask

    task automatic issue_one(input string tag);
        int a0, t;
        a0 = ar_cnt; ar_quota = ar_cnt + 1; arready_en = 1; enable = 1;
        for (t = 0; t < 50 && ar_cnt == a0; t++) cyc(1);
        enable = 0;
        checks++;
        if (ar_cnt != a0 + 1) begin errors++; $display("FAIL %s_issue: got %0d expected %0d", tag, ar_cnt - a0, 1); end
    endtask

    task automatic test_reset();
        do_reset();
        cyc(1);
        checks += 11;
        if (arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b expected 0", arvalid); end
        if (araddr !== 32'h0) begin errors++; $display("FAIL rst_araddr: got %h expected 0", araddr); end
        if (rready !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b expected 0", rready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
        if (done_cnt !== 16'd0) begin errors++; $display("FAIL rst_done: got %0d expected 0", done_cnt); end
        if (arlen !== 8'd3) begin errors++; $display("FAIL arlen: got %0d expected 3", arlen); end
        if (arsize !== 3'd2) begin errors++; $display("FAIL arsize: got %0d expected 2", arsize); end
        if (arburst !== 2'b01) begin errors++; $display("FAIL arburst: got %0d expected 1", arburst); end
        if (arid !== 4'd0) begin errors++; $display("FAIL arid: got %0d expected 0", arid); end
        if (w_araddr !== 8'hF0) begin errors++; $display("FAIL rst_w_araddr: got %h expected f0", w_araddr); end
    endtask

    task automatic test_basic();
        int t;
        enable = 1;
        for (t = 0; t < 100 && ar_cnt < 3; t++) cyc(1);
        enable = 0;
        drain("basic");
        checks += 3;
        if (ar_cnt != 3) begin errors++; $display("FAIL basic_ars: got %0d expected 3", ar_cnt); end
        if (done_cnt !== 16'd3) begin errors++; $display("FAIL basic_done: got %0d expected 3", done_cnt); end
        if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", err); end
    endtask

    task automatic test_ost_limit();
        int a0;
        a0 = ar_cnt; serve_limit = served; enable = 1;
        cyc(25);
        checks += 3;
        if (ar_cnt - a0 != 4) begin errors++; $display("FAIL ost_limit_ars: got %0d expected 4", ar_cnt - a0); end
        if (arvalid !== 1'b0) begin errors++; $display("FAIL ost_limit_arvalid: got %b expected 0", arvalid); end
        if (busy !== 1'b1) begin errors++; $display("FAIL ost_limit_busy: got %b expected 1", busy); end
        serve_limit = served + 1;
        cyc(30);
        checks += 2;
        if (ar_cnt - a0 != 5) begin errors++; $display("FAIL ost_release_ars: got %0d expected 5", ar_cnt - a0); end
        if (arvalid !== 1'b0) begin errors++; $display("FAIL ost_release_arvalid: got %b expected 0", arvalid); end
        drain("ost");
    endtask

    task automatic test_backpressure();
        int a0, t;
        logic [31:0] a_hold;
        a0 = ar_cnt; arready_en = 0; enable = 1;
        for (t = 0; t < 10 && !arvalid; t++) cyc(1);
        enable = 0; a_hold = araddr;
        checks++;
        if (arvalid !== 1'b1) begin errors++; $display("FAIL bp_arvalid_rise: got %b expected 1", arvalid); end
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            checks++;
            if (arvalid !== 1'b1 || araddr !== a_hold) begin
                errors++; $display("FAIL bp_hold: got v=%b a=%h expected v=1 a=%h", arvalid, araddr, a_hold);
            end
        end
        arready_en = 1;
        cyc(10);
        checks += 2;
        if (ar_cnt - a0 != 1) begin errors++; $display("FAIL bp_ars: got %0d expected 1", ar_cnt - a0); end
        if (arvalid !== 1'b0) begin errors++; $display("FAIL bp_arvalid_end: got %b expected 0", arvalid); end
        drain("bp");
    endtask

    task automatic test_simultaneous();
        int a0, t;
        logic [2:0] ost_obs;
        a0 = ar_cnt; serve_limit = served; ar_quota = ar_cnt + 2; enable = 1;
        cyc(12);
        checks += 2;
        if (ar_cnt - a0 != 2) begin errors++; $display("FAIL sim_ars: got %0d expected 2", ar_cnt - a0); end
        if (arvalid !== 1'b1) begin errors++; $display("FAIL sim_req: got %b expected 1", arvalid); end
        simul_seen = 0; sync_ar = 1; serve_limit = served + 1;
        for (t = 0; t < 40 && !simul_seen; t++) cyc(1);
        ost_obs = dut.u_ost.count;
        checks += 2;
        if (simul_seen !== 1'b1) begin errors++; $display("FAIL sim_joint: got %b expected 1", simul_seen); end
        if (ost_obs !== 3'd2) begin errors++; $display("FAIL sim_ost: got %0d expected 2", ost_obs); end
        drain("sim");
    endtask

    task automatic test_random();
        int a0;
        a0 = ar_cnt; gaps = 1; ar_rand = 1;
        for (int i = 0; i < 300; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        drain("rand");
        gaps = 0;
        checks += 3;
        if (ar_cnt - a0 < 10) begin errors++; $display("FAIL rand_progress: got %0d expected >=10", ar_cnt - a0); end
        if (done_cnt !== 16'(ar_cnt)) begin errors++; $display("FAIL rand_done: got %0d expected %0d", done_cnt, ar_cnt); end
        if (err !== 1'b0) begin errors++; $display("FAIL rand_err: got %b expected 0", err); end
    endtask

    task automatic test_err_resp();
        int d0;
        d0 = exp_done; inj_bad = 1;
        issue_one("eresp");
        inj_bad = -1;
        drain("eresp");
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL eresp_err: got %b expected 1", err); end
        issue_one("eresp2");
        drain("eresp2");
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL eresp_sticky: got %b expected 1", err); end
        if (done_cnt !== 16'(d0 + 2)) begin errors++; $display("FAIL eresp_done: got %0d expected %0d", done_cnt, d0 + 2); end
    endtask

    task automatic test_early_last();
        logic [1:0] bc;
        inj_len = 2;
        issue_one("early");
        inj_len = 4;
        drain("early");
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL early_err: got %b expected 1", err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL early_busy: got %b expected 0", busy); end
        issue_one("early2");
        drain("early2");
        bc = dut.beat_cnt;
        checks += 2;
        if (done_cnt !== 16'd2) begin errors++; $display("FAIL early_done: got %0d expected 2", done_cnt); end
        if (bc !== 2'd0) begin errors++; $display("FAIL early_beat: got %0d expected 0", bc); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_w;
        int n;
        exp_w = 8'hF0; n = 0; w_enable = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (w_arvalid && w_arready) begin
                checks++;
                if (w_araddr !== exp_w) begin errors++; $display("FAIL wrap_addr: got %h expected %h", w_araddr, exp_w); end
                exp_w = exp_w + 8'h10; n++;
            end
        end
        w_enable = 0;
        cyc(1);
        checks += 2;
        if (n != 4) begin errors++; $display("FAIL wrap_ars: got %0d expected 4", n); end
        if (w_busy !== 1'b1) begin errors++; $display("FAIL wrap_busy: got %b expected 1", w_busy); end
    endtask

    task automatic test_async_reset();
        enable = 1;
        cyc(9);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ares_pre_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks += 10;
        if (arvalid !== 1'b0) begin errors++; $display("FAIL ares_arvalid: got %b expected 0", arvalid); end
        if (araddr !== 32'h0) begin errors++; $display("FAIL ares_araddr: got %h expected 0", araddr); end
        if (rready !== 1'b0) begin errors++; $display("FAIL ares_rready: got %b expected 0", rready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ares_busy: got %b expected 0", busy); end
        if (err !== 1'b0) begin errors++; $display("FAIL ares_err: got %b expected 0", err); end
        if (done_cnt !== 16'd0) begin errors++; $display("FAIL ares_done: got %0d expected 0", done_cnt); end
        if (w_araddr !== 8'hF0) begin errors++; $display("FAIL ares_w_addr: got %h expected f0", w_araddr); end
        if (w_busy !== 1'b0) begin errors++; $display("FAIL ares_w_busy: got %b expected 0", w_busy); end
        if (w_rready !== 1'b0) begin errors++; $display("FAIL ares_w_rready: got %b expected 0", w_rready); end
        if (w_arvalid !== 1'b0) begin errors++; $display("FAIL ares_w_arvalid: got %b expected 0", w_arvalid); end
        do_reset();
        cyc(2);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ares_post_busy: got %b expected 0", busy); end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_basic();
        test_ost_limit();
        test_backpressure();
        test_simultaneous();
        test_random();
        test_err_resp();
        do_reset();
        test_early_last();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
